// File: rtl/transmitter_control_unit.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// transmitter_control_unit
//
// Purpose
//   Control unit for a UART transmit datapath. Sequences an external transmit
//   shift register (load, shift) and builds the serial frame:
//   start bit, DATA_WIDTH data bits LSB-first, optional parity bit, and
//   STOP_BITS stop bits. Owns the baud-rate bit timer and the valid/ready
//   handshake with the upstream byte source.
//
// Parameters
//   DATA_WIDTH    data bits per frame, equal to the shift register width (>=1)
//   CLKS_PER_BIT  i_clock cycles per serial bit (>=2)
//   PARITY_EN     1 = parity bit after the data bits, 0 = no parity bit
//   PARITY_ODD    0 = even parity, 1 = odd parity (unused when PARITY_EN=0)
//   STOP_BITS     number of stop bits, 1 or 2
//
// Ports
//   i_clock         in   system clock, rising edge
//   i_async_resetL  in   asynchronous active-low reset
//   i_tx_valid      in   upstream byte available on the shift register load bus
//   o_tx_ready      out  controller idle, accepts a byte this cycle
//   o_ld_en         out  load strobe to the shift register
//   o_shift_en      out  shift strobe to the shift register
//   i_shift_out     in   shift register bit 0 (current data bit)
//   o_tx            out  serial line, idle high
//   o_busy          out  frame in progress
//   o_done          out  one-cycle pulse on the final clock of the last stop bit
// -----------------------------------------------------------------------------
module transmitter_control_unit #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic i_clock,
   input  logic i_async_resetL,
   input  logic i_tx_valid,
   output logic o_tx_ready,
   output logic o_ld_en,
   output logic o_shift_en,
   input  logic i_shift_out,
   output logic o_tx,
   output logic o_busy,
   output logic o_done
);

   localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int INDEX_W = $clog2(DATA_WIDTH + 1);

   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [INDEX_W-1:0] LAST_DATA = INDEX_W'(DATA_WIDTH - 1);
   // The bit index is reused to count stop bits; STOP_BITS <= 2 always fits.
   localparam logic [INDEX_W-1:0] LAST_STOP = INDEX_W'(STOP_BITS - 1);

   localparam logic PARITY_INV = (PARITY_ODD != 0);
   localparam bit   HAS_PARITY = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [TIMER_W-1:0]  r_bit_timer;
   logic [TIMER_W-1:0]  w_bit_timer_nxt;
   logic [INDEX_W-1:0]  r_bit_idx;
   logic [INDEX_W-1:0]  w_bit_idx_nxt;
   logic                r_parity;
   logic                w_parity_nxt;
   logic                w_bit_end;

   assign w_bit_end = (r_bit_timer == TIMER_MAX);

   // ---------------------------------------------------------------------------
   // State and counter registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational process.
   always_ff @(posedge i_clock or negedge i_async_resetL) begin
      if (!i_async_resetL) begin
         r_state     <= S_IDLE;
         r_bit_timer <= '0;
         r_bit_idx   <= '0;
         r_parity    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_timer <= w_bit_timer_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_parity    <= w_parity_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and strobe logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_timer_nxt = r_bit_timer + 1'b1;
      w_bit_idx_nxt   = r_bit_idx;
      w_parity_nxt    = r_parity;
      o_ld_en         = 1'b0;
      o_shift_en      = 1'b0;
      o_done          = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_bit_timer_nxt = '0;
            w_bit_idx_nxt   = '0;
            // Load and transfer happen on the same edge, so the shift
            // register holds the byte when START begins.
            if (i_tx_valid) begin
               o_ld_en      = 1'b1;
               w_parity_nxt = 1'b0;
               w_state_nxt  = S_START;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_bit_timer_nxt = '0;
               w_state_nxt     = S_DATA;
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               // The bit on i_shift_out is the one just sent; fold it into
               // parity before the shift replaces it.
               o_shift_en      = 1'b1;
               w_parity_nxt    = r_parity ^ i_shift_out;
               w_bit_timer_nxt = '0;
               if (r_bit_idx == LAST_DATA) begin
                  w_bit_idx_nxt = '0;
                  w_state_nxt   = HAS_PARITY ? S_PARITY : S_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end

         S_PARITY: begin
            if (w_bit_end) begin
               w_bit_timer_nxt = '0;
               w_state_nxt     = S_STOP;
            end
         end

         S_STOP: begin
            if (w_bit_end) begin
               w_bit_timer_nxt = '0;
               if (r_bit_idx == LAST_STOP) begin
                  o_done        = 1'b1;
                  w_bit_idx_nxt = '0;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end

         default: begin
            w_bit_timer_nxt = '0;
            w_bit_idx_nxt   = '0;
            w_state_nxt     = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Serial line and status outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      o_tx = 1'b1;
      case (r_state)
         S_START:  o_tx = 1'b0;
         S_DATA:   o_tx = i_shift_out;
         S_PARITY: o_tx = r_parity ^ PARITY_INV;
         default:  o_tx = 1'b1;
      endcase
   end

   assign o_tx_ready = (r_state == S_IDLE);
   assign o_busy     = (r_state != S_IDLE);

endmodule
